// File: rtl/riscv_32m_pkg.sv
// Shared constants for the RV32M issue controller: FSM state encoding and func3 opcodes.
package riscv_32m_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  // func3[2] separates the divider family from the multiplier family.
  function automatic logic is_div_op(input logic [2:0] f3);
    return f3[2];
  endfunction

endpackage

// File: rtl/riscv_32m_issue_ctrl.sv
// Issue/sequencing stage in front of the pipelined RV32M ALU: holds operands for the
// ALU latency, stalls the core, and hands the captured result to writeback.
module riscv_32m_issue_ctrl
  import riscv_32m_pkg::*;
#(
  parameter int DIV_STAGES = 1,
  parameter int MUL_STAGES = 0,
  parameter int CNT_W      = 4
) (
  input  logic        clock_i,
  input  logic        resetn_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [2:0]  func3_i,
  input  logic [31:0] src1_i,
  input  logic [31:0] src2_i,
  input  logic [4:0]  rd_i,
  input  logic        flush_i,
  output logic [31:0] alu_in0_o,
  output logic [31:0] alu_in1_o,
  output logic [2:0]  alu_func3_o,
  input  logic [31:0] alu_result_i,
  output logic        stall_o,
  output logic        wb_valid_o,
  input  logic        wb_ready_i,
  output logic [4:0]  wb_rd_o,
  output logic [31:0] wb_data_o,
  output logic [1:0]  dbg_state_o
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
  // The upstream request must not depend on req_ready_o; the result stays stable while
  // wb_valid_o is high and wb_ready_i is low.

  logic [1:0]       state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             cnt_zero;
  logic             capture;

  assign accept   = req_valid_i & req_ready_o;
  assign cnt_zero = (cnt == '0);
  // A flush in BUSY wins over the final capture cycle.
  assign capture  = (state == ST_BUSY) & ~flush_i & cnt_zero;

  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) state <= ST_IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = ST_BUSY;
      ST_BUSY: begin
        if (flush_i)       state_nxt = ST_IDLE;
        else if (cnt_zero) state_nxt = (wb_rd_o != 5'd0) ? ST_DONE : ST_IDLE;
      end
      ST_DONE: if (wb_ready_i) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready_o = 1'b0;
    stall_o     = 1'b0;
    wb_valid_o  = 1'b0;
    dbg_state_o = state;
    case (state)
      ST_IDLE: req_ready_o = resetn_i & ~flush_i;
      ST_BUSY: stall_o     = 1'b1;
      ST_DONE: begin
        wb_valid_o = 1'b1;
        stall_o    = ~wb_ready_i;
      end
      default: ;
    endcase
  end

  // Operands, func3 and rd change only on accept so the ALU sees a consistent set.
  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      alu_in0_o   <= '0;
      alu_in1_o   <= '0;
      alu_func3_o <= '0;
      wb_rd_o     <= '0;
      cnt         <= '0;
      wb_data_o   <= '0;
    end else begin
      if (accept) begin
        alu_in0_o   <= src1_i;
        alu_in1_o   <= src2_i;
        alu_func3_o <= func3_i;
        wb_rd_o     <= rd_i;
        cnt         <= is_div_op(func3_i) ? CNT_W'(DIV_STAGES) : CNT_W'(MUL_STAGES);
      end else if ((state == ST_BUSY) && !cnt_zero) begin
        cnt <= cnt - 1'b1;
      end
      if (capture) wb_data_o <= alu_result_i;
    end
  end

endmodule

// File: tb/tb_riscv_32m_issue_ctrl.sv
// Self-checking bench for riscv_32m_issue_ctrl: directed test-plan steps, then random ops
// scored against an arithmetic RV32M reference and a per-op latency model.
module tb_riscv_32m_issue_ctrl;
  import riscv_32m_pkg::*;

  localparam int DIV_ST = 1;
  localparam int MUL_ST = 0;

  logic        clock_i = 1'b0;
  logic        resetn_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [2:0]  func3_i;
  logic [31:0] src1_i, src2_i;
  logic [4:0]  rd_i;
  logic        flush_i;
  logic [31:0] alu_in0_o, alu_in1_o;
  logic [2:0]  alu_func3_o;
  logic [31:0] alu_result_i;
  logic        stall_o;
  logic        wb_valid_o;
  logic        wb_ready_i;
  logic [4:0]  wb_rd_o;
  logic [31:0] wb_data_o;
  logic [1:0]  dbg_state_o;

  int vectors = 0;
  int errors  = 0;
  logic [31:0] exp_q[$];

  // clock / reset
  always #5 clock_i = ~clock_i;

  riscv_32m_issue_ctrl #(.DIV_STAGES(DIV_ST), .MUL_STAGES(MUL_ST), .CNT_W(4)) dut (
    .clock_i(clock_i), .resetn_i(resetn_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .func3_i(func3_i), .src1_i(src1_i), .src2_i(src2_i), .rd_i(rd_i),
    .flush_i(flush_i),
    .alu_in0_o(alu_in0_o), .alu_in1_o(alu_in1_o), .alu_func3_o(alu_func3_o),
    .alu_result_i(alu_result_i),
    .stall_o(stall_o), .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i),
    .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o), .dbg_state_o(dbg_state_o)
  );

  // RV32M arithmetic from the ISA definition (including divide-by-zero and overflow).
  function automatic logic [31:0] rv32m_ref(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [63:0] sa, sb, za, zb, p;
    logic        ovf;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    za  = {32'd0, a};
    zb  = {32'd0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f3)
      F3_MUL:    begin p = sa * sb; return p[31:0];  end
      F3_MULH:   begin p = sa * sb; return p[63:32]; end
      F3_MULHSU: begin p = sa * zb; return p[63:32]; end
      F3_MULHU:  begin p = za * zb; return p[63:32]; end
      F3_DIV:    return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
      F3_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      F3_REM:    return (b == 0) ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
      default:   return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Behavioural ALU: operands are held constant, so only the registered inputs matter.
  assign alu_result_i = rv32m_ref(alu_func3_o, alu_in0_o, alu_in1_o);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock_i);
    @(negedge clock_i);
  endtask

  // Drive one op from a negedge in IDLE; returns at a negedge back in IDLE.
  task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] exp, input int hold);
    int          n;
    logic [31:0] e;
    n = f3[2] ? DIV_ST : MUL_ST;
    chk("idle_ready", 32'(req_ready_o), 32'd1);
    chk("idle_stall", 32'(stall_o), 32'd0);
    req_valid_i = 1'b1; func3_i = f3; src1_i = a; src2_i = b; rd_i = rd; wb_ready_i = 1'b0;
    if (rd != 5'd0) exp_q.push_back(exp);
    tick();
    req_valid_i = 1'b0;
    src1_i = $urandom; src2_i = $urandom; func3_i = 3'($urandom); rd_i = 5'($urandom);
    for (int k = 0; k <= n; k++) begin
      chk("busy_stall", 32'(stall_o), 32'd1);
      chk("busy_wbv", 32'(wb_valid_o), 32'd0);
      chk("busy_ready", 32'(req_ready_o), 32'd0);
      chk("busy_in0", alu_in0_o, a);
      chk("busy_in1", alu_in1_o, b);
      chk("busy_f3", 32'(alu_func3_o), 32'(f3));
      tick();
    end
    if (rd != 5'd0) begin
      e = exp_q.pop_front();
      chk("done_wbv", 32'(wb_valid_o), 32'd1);
      chk("done_data", wb_data_o, e);
      chk("done_rd", 32'(wb_rd_o), 32'(rd));
      chk("done_stall", 32'(stall_o), 32'd1);
      for (int h = 0; h < hold; h++) begin
        tick();
        chk("hold_wbv", 32'(wb_valid_o), 32'd1);
        chk("hold_data", wb_data_o, e);
        chk("hold_rd", 32'(wb_rd_o), 32'(rd));
        chk("hold_stall", 32'(stall_o), 32'd1);
      end
      wb_ready_i = 1'b1;
      #1 chk("handoff_stall", 32'(stall_o), 32'd0);
      tick();
      wb_ready_i = 1'b0;
      chk("post_wbv", 32'(wb_valid_o), 32'd0);
      chk("post_state", 32'(dbg_state_o), 32'(ST_IDLE));
    end else begin
      chk("x0_wbv", 32'(wb_valid_o), 32'd0);
      chk("x0_ready", 32'(req_ready_o), 32'd1);
      chk("x0_stall", 32'(stall_o), 32'd0);
    end
  endtask

  initial begin
    logic [2:0]  rf3;
    logic [31:0] ra, rb;
    logic [4:0]  rrd;
    resetn_i = 1'b0; req_valid_i = 1'b0; func3_i = '0; src1_i = '0; src2_i = '0;
    rd_i = '0; flush_i = 1'b0; wb_ready_i = 1'b0;
    @(negedge clock_i);
    chk("rst_ready", 32'(req_ready_o), 32'd0);
    chk("rst_stall", 32'(stall_o), 32'd0);
    chk("rst_wbv", 32'(wb_valid_o), 32'd0);
    chk("rst_data", wb_data_o, 32'd0);
    chk("rst_in0", alu_in0_o, 32'd0);
    chk("rst_state", 32'(dbg_state_o), 32'(ST_IDLE));
    tick();
    resetn_i = 1'b1;
    tick();

    // Directed test-plan steps.
    do_op(F3_MUL, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, 0);
    do_op(F3_DIV, 32'd100, 32'd7, 5'd3, 32'd14, 0);
    do_op(F3_REM, 32'd100, 32'd7, 5'd3, 32'd2, 0);
    do_op(F3_DIVU, 32'd50, 32'd5, 5'd0, 32'd10, 0);
    do_op(F3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd12, 32'hFFFF_FFFE, 4);

    // Flush during the first BUSY cycle of a divide.
    req_valid_i = 1'b1; func3_i = F3_DIV; src1_i = 32'd81; src2_i = 32'd9; rd_i = 5'd9;
    tick();
    req_valid_i = 1'b0; flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("flush_state", 32'(dbg_state_o), 32'(ST_IDLE));
    chk("flush_wbv", 32'(wb_valid_o), 32'd0);
    chk("flush_stall", 32'(stall_o), 32'd0);
    tick();
    chk("flush_wbv2", 32'(wb_valid_o), 32'd0);

    // Flush together with a request in IDLE blocks the accept.
    req_valid_i = 1'b1; flush_i = 1'b1; func3_i = F3_MUL; src1_i = 32'hDEAD_BEEF; rd_i = 5'd4;
    #1 chk("flush_req_ready", 32'(req_ready_o), 32'd0);
    tick();
    req_valid_i = 1'b0; flush_i = 1'b0;
    chk("flush_req_state", 32'(dbg_state_o), 32'(ST_IDLE));
    chk("flush_req_in0", alu_in0_o, 32'd81);
    chk("flush_req_stall", 32'(stall_o), 32'd0);

    // Asynchronous reset in the middle of a BUSY divide.
    req_valid_i = 1'b1; func3_i = F3_DIVU; src1_i = 32'd1000; src2_i = 32'd10; rd_i = 5'd7;
    tick();
    req_valid_i = 1'b0;
    #2 resetn_i = 1'b0;
    #1;
    chk("arst_state", 32'(dbg_state_o), 32'(ST_IDLE));
    chk("arst_stall", 32'(stall_o), 32'd0);
    chk("arst_ready", 32'(req_ready_o), 32'd0);
    chk("arst_in0", alu_in0_o, 32'd0);
    chk("arst_rd", 32'(wb_rd_o), 32'd0);
    @(negedge clock_i);
    resetn_i = 1'b1;
    tick();
    do_op(F3_DIVU, 32'd1000, 32'd10, 5'd7, 32'd100, 1);

    // Random ops checked against the arithmetic reference.
    for (int i = 0; i < 40; i++) begin
      rf3 = 3'($urandom_range(0, 7));
      ra  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      rb  = ($urandom_range(0, 5) == 0) ? 32'd0 :
            ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFF : $urandom;
      rrd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      do_op(rf3, ra, rb, rrd, rv32m_ref(rf3, ra, rb), $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  // Global time bound so a stuck run still terminates.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
